// File: rtl/irq_pkg.sv
// Shared constants, state encoding and arbitration helper for the interrupt controller.
package irq_pkg;

   localparam int N_SRC = 3;

   // Register addresses
   localparam logic [1:0] ADDR_ENABLE  = 2'd0;
   localparam logic [1:0] ADDR_PENDING = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_CONTROL = 2'd3;

   // CONTROL bit positions
   localparam int CTRL_GEN_BIT = 0;
   localparam int CTRL_RR_BIT  = 1;

   // STATUS bit positions
   localparam int STAT_STATE_LSB = 0;  // 2 bits
   localparam int STAT_ISV_LSB   = 2;  // 2 bits
   localparam int STAT_VLD_BIT   = 4;

   // Round-robin pointer value after reset, so the first search starts at source 0
   localparam logic [1:0] RR_RESET = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   // Picks the first eligible source, searching upward from a start index with wrap.
   // Fixed mode starts at 0, which makes the lowest index (the timer) the winner.
   function automatic logic [1:0] arb_pick(input logic [N_SRC-1:0] elig,
                                           input logic             rr,
                                           input logic [1:0]       last);
      logic [1:0] start;
      logic [1:0] idx;
      arb_pick = 2'd0;
      start    = (rr && last != 2'd2) ? last + 2'd1 : 2'd0;
      // Walk from the far end back toward the start so the earliest candidate wins.
      for (int k = N_SRC - 1; k >= 0; k--) begin
         idx = 2'((int'(start) + k) % N_SRC);
         if (elig[idx]) arb_pick = idx;
      end
   endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for one interrupt line.
// The rise pulse is high for the one cycle where the synchronized level first reads 1,
// so a held level produces a single pulse.
module irq_edge_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic s1_q, s2_q, s3_q;

   // Synchronizer chain plus the delayed copy used for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/irq_controller.sv
// Three-source interrupt controller: edge-conditioned inputs, CPU register file,
// fixed or round-robin arbitration and an IDLE/REQ/SERVICE request FSM.
// Handshake: irq_req stays high with irq_vec stable until the CPU pulses irq_ack
// (accepted only in REQ); irq_eoi (accepted only in SERVICE) ends the handler.
module irq_controller
   import irq_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_in,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [7:0]       cfg_wdata,
   output logic [7:0]       cfg_rdata,
   output logic             irq_req,
   output logic [1:0]       irq_vec,
   input  logic             irq_ack,
   input  logic             irq_eoi
);

   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] en_q, pend_q, pend_d;
   logic [1:0]       ctrl_q;
   state_e           state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [1:0]       last_q, last_d;
   logic [1:0]       isv_vec_q, isv_vec_d;
   logic             isv_vld_q, isv_vld_d;
   logic [N_SRC-1:0] eligible, ack_clr, w1c;
   logic [1:0]       winner;

   for (genvar g = 0; g < N_SRC; g++) begin : g_sync
      irq_edge_sync u_sync (
         .clk_i  (clk),
         .rst_ni (reset),
         .d_i    (irq_in[g]),
         .rise_o (rise[g])
      );
   end

   // Eligibility, arbitration winner and write-1-clear mask
   always_comb begin
      eligible = ctrl_q[CTRL_GEN_BIT] ? (pend_q & en_q) : '0;
      winner   = arb_pick(eligible, ctrl_q[CTRL_RR_BIT], last_q);
      w1c      = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata[N_SRC-1:0] : '0;
   end

   // Request FSM next state, latched vector, in-service tracking and ack-driven clear
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      last_d    = last_q;
      isv_vec_d = isv_vec_q;
      isv_vld_d = isv_vld_q;
      ack_clr   = '0;
      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               state_d = ST_REQ;
               vec_d   = winner;
            end
         end
         ST_REQ: begin
            // A source that lost eligibility withdraws the request even if ack arrives together
            if (!eligible[vec_q]) begin
               state_d = ST_IDLE;
            end else if (irq_ack) begin
               state_d        = ST_SERVICE;
               ack_clr[vec_q] = 1'b1;
               isv_vec_d      = vec_q;
               isv_vld_d      = 1'b1;
               last_d         = vec_q;
            end
         end
         ST_SERVICE: begin
            if (irq_eoi) begin
               state_d   = ST_IDLE;
               isv_vld_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A new edge on the same cycle as a clear keeps the bit set
      pend_d = (pend_q & ~(w1c | ack_clr)) | rise;
   end

   // Register file and FSM state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q      <= '0;
         pend_q    <= '0;
         ctrl_q    <= '0;
         state_q   <= ST_IDLE;
         vec_q     <= 2'd0;
         last_q    <= RR_RESET;
         isv_vec_q <= 2'd0;
         isv_vld_q <= 1'b0;
      end else begin
         if (cfg_we && cfg_addr == ADDR_ENABLE)  en_q   <= cfg_wdata[N_SRC-1:0];
         if (cfg_we && cfg_addr == ADDR_CONTROL) ctrl_q <= cfg_wdata[1:0];
         pend_q    <= pend_d;
         state_q   <= state_d;
         vec_q     <= vec_d;
         last_q    <= last_d;
         isv_vec_q <= isv_vec_d;
         isv_vld_q <= isv_vld_d;
      end
   end

   // Combinational register read; unused bits read as zero
   always_comb begin
      cfg_rdata = 8'h00;
      case (cfg_addr)
         ADDR_ENABLE:  cfg_rdata[N_SRC-1:0] = en_q;
         ADDR_PENDING: cfg_rdata[N_SRC-1:0] = pend_q;
         ADDR_STATUS: begin
            cfg_rdata[STAT_STATE_LSB +: 2] = state_q;
            cfg_rdata[STAT_ISV_LSB +: 2]   = isv_vec_q;
            cfg_rdata[STAT_VLD_BIT]        = isv_vld_q;
         end
         default:      cfg_rdata[1:0] = ctrl_q;
      endcase
   end

   assign irq_req = (state_q == ST_REQ);
   assign irq_vec = vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a vector table for single-request scenarios plus
// hand-written sequences for arbitration order, withdrawal, set-vs-clear and async reset.
module tb_irq_controller;
   import irq_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] irq_in;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic [7:0] cfg_rdata;
   logic       irq_req;
   logic [1:0] irq_vec;
   logic       irq_ack;
   logic       irq_eoi;

   int checks   = 0;
   int failures = 0;

   irq_controller dut (
      .clk       (clk),
      .reset     (reset),
      .irq_in    (irq_in),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .irq_req   (irq_req),
      .irq_vec   (irq_vec),
      .irq_ack   (irq_ack),
      .irq_eoi   (irq_eoi)
   );

   // Clock
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] en;
      logic [1:0] ctrl;
      logic [2:0] pat;
      logic       exp_req;
      logic [1:0] exp_vec;
   } vec_t;

   vec_t tbl[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic read_check(input string name, input logic [1:0] addr, input logic [7:0] exp);
      cfg_addr = addr;
      #1;
      check(name, cfg_rdata, exp);
   endtask

   task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
      cfg_we    = 1'b1;
      cfg_addr  = addr;
      cfg_wdata = data;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_req(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (irq_req) break;
         tick();
      end
      check(name, {7'b0, irq_req}, 8'h01);
   endtask

   task automatic pulse_in(input logic [2:0] pat);
      irq_in = pat;
      tick();
      irq_in = 3'b000;
   endtask

   task automatic do_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic do_eoi();
      irq_eoi = 1'b1;
      tick();
      irq_eoi = 1'b0;
   endtask

   initial begin
      logic [2:0] onehot;
      logic [1:0] rr_exp[4];

      reset     = 1'b0;
      irq_in    = 3'b000;
      cfg_we    = 1'b0;
      cfg_addr  = 2'd0;
      cfg_wdata = 8'h00;
      irq_ack   = 1'b0;
      irq_eoi   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      tick();

      // Reset state
      check("reset_req", {7'b0, irq_req}, 8'h00);
      check("reset_vec", {6'b0, irq_vec}, 8'h00);
      read_check("reset_enable", ADDR_ENABLE, 8'h00);
      read_check("reset_pending", ADDR_PENDING, 8'h00);
      read_check("reset_status", ADDR_STATUS, 8'h00);
      read_check("reset_control", ADDR_CONTROL, 8'h00);

      // Stray ack/eoi in IDLE are ignored
      irq_ack = 1'b1;
      irq_eoi = 1'b1;
      tick();
      irq_ack = 1'b0;
      irq_eoi = 1'b0;
      read_check("stray_ack_status", ADDR_STATUS, 8'h00);

      // en, ctrl, pattern, request expected, winning vector (fixed priority)
      tbl[0] = '{3'b111, 2'd1, 3'b001, 1'b1, 2'd0};
      tbl[1] = '{3'b111, 2'd1, 3'b110, 1'b1, 2'd1};
      tbl[2] = '{3'b111, 2'd1, 3'b111, 1'b1, 2'd0};
      tbl[3] = '{3'b110, 2'd1, 3'b011, 1'b1, 2'd1};
      tbl[4] = '{3'b111, 2'd0, 3'b111, 1'b0, 2'd0};
      tbl[5] = '{3'b011, 2'd1, 3'b100, 1'b0, 2'd0};
      tbl[6] = '{3'b100, 2'd1, 3'b101, 1'b1, 2'd2};

      for (int i = 0; i < 7; i++) begin
         cfg_write(ADDR_ENABLE, {5'b0, tbl[i].en});
         cfg_write(ADDR_CONTROL, {6'b0, tbl[i].ctrl});
         pulse_in(tbl[i].pat);      // edge 1
         tick();                    // edge 2
         tick();                    // edge 3: PENDING set
         read_check($sformatf("t%0d_pending", i), ADDR_PENDING, {5'b0, tbl[i].pat});
         check($sformatf("t%0d_req_early", i), {7'b0, irq_req}, 8'h00);
         tick();                    // edge 4: request if eligible
         check($sformatf("t%0d_req", i), {7'b0, irq_req}, {7'b0, tbl[i].exp_req});
         if (tbl[i].exp_req) begin
            check($sformatf("t%0d_vec", i), {6'b0, irq_vec}, {6'b0, tbl[i].exp_vec});
            onehot = 3'b001 << tbl[i].exp_vec;
            do_ack();
            check($sformatf("t%0d_req_after_ack", i), {7'b0, irq_req}, 8'h00);
            read_check($sformatf("t%0d_pending_after_ack", i), ADDR_PENDING,
                       {5'b0, tbl[i].pat & ~onehot});
            read_check($sformatf("t%0d_status_service", i), ADDR_STATUS,
                       {3'b001, tbl[i].exp_vec, 2'd2});
            do_eoi();
            read_check($sformatf("t%0d_status_eoi", i), ADDR_STATUS,
                       {3'b000, tbl[i].exp_vec, 2'd0});
         end
         cfg_write(ADDR_CONTROL, 8'h00);
         cfg_write(ADDR_PENDING, 8'h07);
         tick();
      end

      // Fixed priority: simultaneous 1 and 2, then 2 after the first handler completes
      do_reset();
      cfg_write(ADDR_ENABLE, 8'h07);
      cfg_write(ADDR_CONTROL, 8'h01);
      pulse_in(3'b110);
      wait_req("fix_first_req", 10);
      check("fix_first_vec", {6'b0, irq_vec}, 8'h01);
      do_ack();
      do_eoi();
      tick();
      check("fix_second_req", {7'b0, irq_req}, 8'h01);
      check("fix_second_vec", {6'b0, irq_vec}, 8'h02);

      // Round-robin: sources re-pended after each grant, order 0,1,2,0
      do_reset();
      rr_exp[0] = 2'd0;
      rr_exp[1] = 2'd1;
      rr_exp[2] = 2'd2;
      rr_exp[3] = 2'd0;
      cfg_write(ADDR_ENABLE, 8'h07);
      cfg_write(ADDR_CONTROL, 8'h03);
      pulse_in(3'b111);
      for (int r = 0; r < 4; r++) begin
         wait_req($sformatf("rr%0d_req", r), 12);
         check($sformatf("rr%0d_vec", r), {6'b0, irq_vec}, {6'b0, rr_exp[r]});
         onehot  = 3'b001 << irq_vec;
         irq_ack = 1'b1;
         irq_in  = onehot;
         tick();
         irq_ack = 1'b0;
         irq_in  = 3'b000;
         do_eoi();
      end

      // Withdrawal: disable the latched source while in REQ
      do_reset();
      cfg_write(ADDR_ENABLE, 8'h04);
      cfg_write(ADDR_CONTROL, 8'h01);
      pulse_in(3'b100);
      wait_req("wd_req", 10);
      check("wd_vec", {6'b0, irq_vec}, 8'h02);
      cfg_write(ADDR_ENABLE, 8'h03);
      tick();
      check("wd_req_dropped", {7'b0, irq_req}, 8'h00);
      read_check("wd_status_idle", ADDR_STATUS, 8'h00);
      read_check("wd_pending_kept", ADDR_PENDING, 8'h04);

      // New edge on source 0 lands on the ack edge of vector 0: set wins
      do_reset();
      cfg_write(ADDR_ENABLE, 8'h01);
      cfg_write(ADDR_CONTROL, 8'h01);
      pulse_in(3'b001);
      wait_req("sw_req", 10);
      check("sw_vec", {6'b0, irq_vec}, 8'h00);
      pulse_in(3'b001);              // edge 1 of the new rise
      tick();                        // edge 2
      do_ack();                      // edge 3: set and ack-clear together
      read_check("sw_pending_kept", ADDR_PENDING, 8'h01);
      read_check("sw_status_service", ADDR_STATUS, 8'h12);
      do_eoi();
      tick();
      check("sw_second_req", {7'b0, irq_req}, 8'h01);
      check("sw_second_vec", {6'b0, irq_vec}, 8'h00);

      // Asynchronous reset while in SERVICE
      do_reset();
      cfg_write(ADDR_ENABLE, 8'h07);
      cfg_write(ADDR_CONTROL, 8'h01);
      pulse_in(3'b110);
      wait_req("ar_req", 10);
      do_ack();
      read_check("ar_status_service", ADDR_STATUS, 8'h16);
      reset = 1'b0;
      #1;
      check("ar_req", {7'b0, irq_req}, 8'h00);
      check("ar_vec", {6'b0, irq_vec}, 8'h00);
      read_check("ar_enable", ADDR_ENABLE, 8'h00);
      read_check("ar_pending", ADDR_PENDING, 8'h00);
      read_check("ar_status", ADDR_STATUS, 8'h00);
      read_check("ar_control", ADDR_CONTROL, 8'h00);
      tick();
      reset = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
